// File: rtl/raytracing_job_dispatcher_if.sv
// Bundle of the dispatcher's frame control, worker-bank and collector signals.
interface raytracing_job_dispatcher_if #(
  parameter int N_WORKERS = 8
) ();
  logic                          frame_start;
  logic signed [13:0]            sphere_y;
  logic [N_WORKERS-1:0]          worker_busy;
  logic                          activate;
  logic [N_WORKERS*12-1:0]       pixel_start_x;
  logic signed [11:0]            pixel_y;
  logic [15:0]                   pixel_y_sqrd;
  logic [26:0]                   sphere_y_sqrd;
  logic signed [21:0]            doty_r;
  logic                          batch_valid;
  logic                          batch_ready;
  logic signed [11:0]            batch_x;
  logic                          frame_busy;
  logic                          frame_done;

  modport master (
    input  frame_start, sphere_y, worker_busy, batch_ready,
    output activate, pixel_start_x, pixel_y, pixel_y_sqrd, sphere_y_sqrd,
           doty_r, batch_valid, batch_x, frame_busy, frame_done
  );

  modport slave (
    output frame_start, sphere_y, worker_busy, batch_ready,
    input  activate, pixel_start_x, pixel_y, pixel_y_sqrd, sphere_y_sqrd,
           doty_r, batch_valid, batch_x, frame_busy, frame_done
  );
endinterface

// File: rtl/raytracing_job_dispatcher.sv
// Scanline/batch scheduler feeding the ray-tracing worker bank and the
// colour-buffer collector. Per-line y terms are computed once in SETUP_LINE.
module raytracing_job_dispatcher #(
  parameter int N_WORKERS        = 8,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int H_RES            = 640,
  parameter int V_RES            = 480,
  parameter int FP_B             = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  raytracing_job_dispatcher_if.master bus
);

  localparam int BATCH = N_WORKERS * JOBS_SUBDIVISION;
  localparam logic signed [11:0] X0 = 12'(-(H_RES / 2));
  localparam logic signed [11:0] Y0 = 12'(V_RES / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP_LINE, LAUNCH, WAIT_BUSY, WAIT_DONE, OFFER, NEXT
  } state_t;

  state_t                    state_q, state_d;
  logic signed [11:0]        y_q, y_d;
  logic signed [11:0]        x_base_q, x_base_d;
  logic signed [13:0]        sph_q, sph_d;
  logic                      activate_q, activate_d;
  logic [N_WORKERS*12-1:0]   psx_q, psx_d;
  logic signed [11:0]        pixel_y_q, pixel_y_d;
  logic [15:0]               pysq_q, pysq_d;
  logic [26:0]               spsq_q, spsq_d;
  logic signed [21:0]        doty_q, doty_d;
  logic                      bvalid_q, bvalid_d;
  logic signed [11:0]        bx_q, bx_d;
  logic                      fbusy_q, fbusy_d;
  logic                      fdone_q, fdone_d;

  // Full-width signed products, truncated to the port widths.
  logic signed [23:0] y_ext24;
  logic signed [25:0] y_ext26, s_ext26;
  logic signed [27:0] s_ext28;
  logic [15:0]        pysq_c;
  logic signed [21:0] doty_c;
  logic [26:0]        spsq_c;

  assign y_ext24 = 24'(y_q);
  assign y_ext26 = 26'(y_q);
  assign s_ext26 = 26'(sph_q);
  assign s_ext28 = 28'(sph_q);
  assign pysq_c  = 16'(y_ext24 * y_ext24);
  assign doty_c  = 22'(y_ext26 * s_ext26);
  assign spsq_c  = 27'((s_ext28 * s_ext28) >>> FP_B);

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      y_q        <= '0;
      x_base_q   <= '0;
      sph_q      <= '0;
      activate_q <= 1'b0;
      psx_q      <= '0;
      pixel_y_q  <= '0;
      pysq_q     <= '0;
      spsq_q     <= '0;
      doty_q     <= '0;
      bvalid_q   <= 1'b0;
      bx_q       <= '0;
      fbusy_q    <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      x_base_q   <= x_base_d;
      sph_q      <= sph_d;
      activate_q <= activate_d;
      psx_q      <= psx_d;
      pixel_y_q  <= pixel_y_d;
      pysq_q     <= pysq_d;
      spsq_q     <= spsq_d;
      doty_q     <= doty_d;
      bvalid_q   <= bvalid_d;
      bx_q       <= bx_d;
      fbusy_q    <= fbusy_d;
      fdone_q    <= fdone_d;
    end
  end

  // Next-state and register updates; everything holds unless a state changes it.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    x_base_d   = x_base_q;
    sph_d      = sph_q;
    activate_d = activate_q;
    psx_d      = psx_q;
    pixel_y_d  = pixel_y_q;
    pysq_d     = pysq_q;
    spsq_d     = spsq_q;
    doty_d     = doty_q;
    bvalid_d   = bvalid_q;
    bx_d       = bx_q;
    fbusy_d    = fbusy_q;
    fdone_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          sph_d    = bus.sphere_y;
          y_d      = Y0;
          x_base_d = X0;
          fbusy_d  = 1'b1;
          state_d  = SETUP_LINE;
        end
      end
      SETUP_LINE: begin
        // Line terms only move here, while activate is low.
        pixel_y_d = y_q;
        pysq_d    = pysq_c;
        doty_d    = doty_c;
        spsq_d    = spsq_c;
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        for (int w = 0; w < N_WORKERS; w++) begin
          psx_d[w*12 +: 12] = x_base_q + 12'(w);
        end
        activate_d = 1'b1;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (|bus.worker_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // activate stays high so the worker buffers keep their results.
        if (bus.worker_busy == '0) begin
          bvalid_d = 1'b1;
          bx_d     = x_base_q;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (bus.batch_ready) begin
          bvalid_d   = 1'b0;
          activate_d = 1'b0;
          state_d    = NEXT;
        end
      end
      NEXT: begin
        if ((int'(x_base_q) + BATCH) < (H_RES / 2)) begin
          x_base_d = x_base_q + 12'(BATCH);
          state_d  = LAUNCH;
        end else if (int'(y_q) > -(V_RES / 2)) begin
          y_d      = y_q - 12'sd1;
          x_base_d = X0;
          state_d  = SETUP_LINE;
        end else begin
          fdone_d = 1'b1;
          fbusy_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.activate      = activate_q;
  assign bus.pixel_start_x = psx_q;
  assign bus.pixel_y       = pixel_y_q;
  assign bus.pixel_y_sqrd  = pysq_q;
  assign bus.sphere_y_sqrd = spsq_q;
  assign bus.doty_r        = doty_q;
  assign bus.batch_valid   = bvalid_q;
  assign bus.batch_x       = bx_q;
  assign bus.frame_busy    = fbusy_q;
  assign bus.frame_done    = fdone_q;

endmodule

// File: tb/tb_raytracing_job_dispatcher.sv
// Bench for raytracing_job_dispatcher: a full-size instance for line setup,
// handshake, wrap and reset, and a 128x2 instance for a complete frame.
module tb_raytracing_job_dispatcher;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  raytracing_job_dispatcher_if #(.N_WORKERS(8)) ia ();
  raytracing_job_dispatcher_if #(.N_WORKERS(8)) ib ();

  raytracing_job_dispatcher #(
    .N_WORKERS(8), .JOBS_SUBDIVISION(8), .H_RES(640), .V_RES(480), .FP_B(4)
  ) u_dut_a (.clk(clk), .rst_(rst_a), .bus(ia));

  raytracing_job_dispatcher #(
    .N_WORKERS(8), .JOBS_SUBDIVISION(8), .H_RES(128), .V_RES(2), .FP_B(4)
  ) u_dut_b (.clk(clk), .rst_(rst_b), .bus(ib));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Worker models: busy one cycle after activate, for 10 cycles, once per activation.
  logic wb_a = 1'b0, ws_a = 1'b0;
  int   wc_a = 0;
  always @(posedge clk) begin
    if (!ia.activate) begin
      wb_a <= 1'b0; ws_a <= 1'b0; wc_a <= 0;
    end else if (!ws_a) begin
      wb_a <= 1'b1; ws_a <= 1'b1; wc_a <= 10;
    end else if (wb_a) begin
      if (wc_a == 1) wb_a <= 1'b0;
      wc_a <= wc_a - 1;
    end
  end
  assign ia.worker_busy = {8{wb_a}};

  logic wb_b = 1'b0, ws_b = 1'b0;
  int   wc_b = 0;
  always @(posedge clk) begin
    if (!ib.activate) begin
      wb_b <= 1'b0; ws_b <= 1'b0; wc_b <= 0;
    end else if (!ws_b) begin
      wb_b <= 1'b1; ws_b <= 1'b1; wc_b <= 10;
    end else if (wb_b) begin
      if (wc_b == 1) wb_b <= 1'b0;
      wc_b <= wc_b - 1;
    end
  end
  assign ib.worker_busy = {8{wb_b}};

  // Scoreboards of expected (batch_x, pixel_y) per offered batch.
  int qx_a[$], qy_a[$], qx_b[$], qy_b[$];
  logic pv_a = 1'b0, pv_b = 1'b0;
  int offers_a = 0, offers_b = 0;

  // Monitor A: compare each newly offered batch against the queue head.
  always @(negedge clk) begin
    int ex, ey;
    if (ia.batch_valid && !pv_a) begin
      offers_a <= offers_a + 1;
      if (qx_a.size() == 0) chk("unexpected_batch_a", 1, 0);
      else begin
        ex = qx_a.pop_front();
        ey = qy_a.pop_front();
        chk("sb_a_batch_x", ia.batch_x, ex);
        chk("sb_a_pixel_y", ia.pixel_y, ey);
      end
    end
    pv_a <= ia.batch_valid;
  end

  // Monitor B: same for the small full-frame instance.
  always @(negedge clk) begin
    int ex, ey;
    if (ib.batch_valid && !pv_b) begin
      offers_b <= offers_b + 1;
      if (qx_b.size() == 0) chk("unexpected_batch_b", 1, 0);
      else begin
        ex = qx_b.pop_front();
        ey = qy_b.pop_front();
        chk("sb_b_batch_x", ib.batch_x, ex);
        chk("sb_b_pixel_y", ib.pixel_y, ey);
      end
    end
    pv_b <= ib.batch_valid;
  end

  initial begin
    int n, lows, acc, done_cnt;
    ia.frame_start = 1'b0; ia.sphere_y = 14'sd100; ia.batch_ready = 1'b0;
    ib.frame_start = 1'b0; ib.sphere_y = 14'sd0;   ib.batch_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_activate", ia.activate, 0);
    chk("rst_batch_valid", ia.batch_valid, 0);
    chk("rst_frame_busy", ia.frame_busy, 0);
    chk("rst_frame_done", ia.frame_done, 0);
    chk("rst_pixel_y", ia.pixel_y, 0);
    chk("rst_doty_r", ia.doty_r, 0);
    chk("rst_batch_x", ia.batch_x, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Expect line 239 (ten batches) then the first batch of line 238.
    for (int k = 0; k < 10; k++) begin
      qx_a.push_back(-320 + 64 * k); qy_a.push_back(239);
    end
    qx_a.push_back(-320); qy_a.push_back(238);

    ia.frame_start = 1'b1;
    @(negedge clk);
    ia.frame_start = 1'b0;

    n = 0;
    while (!ia.activate && n < 50) begin @(negedge clk); n++; end
    chk("first_activate", ia.activate, 1);
    chk("setup_pixel_y", ia.pixel_y, 239);
    chk("setup_pixel_y_sqrd", ia.pixel_y_sqrd, 57121);
    chk("setup_doty_r", ia.doty_r, 23900);
    chk("setup_sphere_y_sqrd", ia.sphere_y_sqrd, 625);
    chk("launch_slice0", $signed(ia.pixel_start_x[0 +: 12]), -320);
    chk("launch_slice7", $signed(ia.pixel_start_x[84 +: 12]), -313);
    chk("frame_busy_high", ia.frame_busy, 1);

    // Ignored start: pulse frame_start with a new sphere_y while waiting on workers.
    n = 0;
    while (!wb_a && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    ia.sphere_y = 14'sd55;
    ia.frame_start = 1'b1;
    @(negedge clk);
    ia.frame_start = 1'b0;
    chk("ignored_start_pixel_y", ia.pixel_y, 239);
    chk("ignored_start_doty", ia.doty_r, 23900);
    chk("ignored_start_activate", ia.activate, 1);

    // Batch offered with batch_ready held low must stay stable.
    n = 0;
    while (!ia.batch_valid && n < 50) begin @(negedge clk); n++; end
    chk("batch_valid_rise", ia.batch_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_batch_valid", ia.batch_valid, 1);
      chk("hold_batch_x", ia.batch_x, -320);
    end
    chk("hold_activate", ia.activate, 1);
    chk("hold_slice0", $signed(ia.pixel_start_x[0 +: 12]), -320);

    ia.batch_ready = 1'b1;
    @(negedge clk);
    ia.batch_ready = 1'b0;
    chk("accept_batch_valid", ia.batch_valid, 0);
    chk("accept_activate", ia.activate, 0);
    lows = 0; n = 0;
    while (!ia.activate && n < 50) begin lows++; @(negedge clk); n++; end
    chk("second_activate", ia.activate, 1);
    chk("activate_gap_ok", (lows >= 1) ? 1 : 0, 1);
    chk("second_slice0", $signed(ia.pixel_start_x[0 +: 12]), -256);
    chk("second_slice7", $signed(ia.pixel_start_x[84 +: 12]), -249);

    // Run on to the first batch of the next scanline.
    ia.batch_ready = 1'b1;
    acc = 1; n = 0;
    while (acc < 11 && n < 3000) begin
      @(negedge clk); n++;
      if (ia.batch_valid && ia.batch_ready) acc++;
    end
    chk("line_wrap_reached", acc, 11);
    chk("wrap_pixel_y", ia.pixel_y, 238);
    chk("wrap_pixel_y_sqrd", ia.pixel_y_sqrd, 56644);
    chk("wrap_doty_r", ia.doty_r, 23800);
    chk("wrap_sphere_y_sqrd", ia.sphere_y_sqrd, 625);
    chk("wrap_batch_x", ia.batch_x, -320);

    // Asynchronous reset while the next batch waits for the workers.
    n = 0;
    while (!wb_a && n < 50) begin @(negedge clk); n++; end
    chk("reach_wait_done", wb_a, 1);
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("async_rst_activate", ia.activate, 0);
    chk("async_rst_batch_valid", ia.batch_valid, 0);
    chk("async_rst_frame_busy", ia.frame_busy, 0);
    chk("async_rst_pixel_y", ia.pixel_y, 0);
    chk("sb_a_remaining", qx_a.size(), 0);
    @(negedge clk);
    rst_a = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ia.frame_done) done_cnt++;
    end
    chk("post_rst_no_done", done_cnt, 0);
    chk("post_rst_idle_activate", ia.activate, 0);
    chk("post_rst_idle_busy", ia.frame_busy, 0);

    // Full small frame with batch_ready tied high.
    qx_b.push_back(-64); qy_b.push_back(0);
    qx_b.push_back(0);   qy_b.push_back(0);
    qx_b.push_back(-64); qy_b.push_back(-1);
    qx_b.push_back(0);   qy_b.push_back(-1);
    ib.frame_start = 1'b1;
    @(negedge clk);
    ib.frame_start = 1'b0;
    chk("b_frame_busy", ib.frame_busy, 1);
    done_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ib.frame_done) done_cnt++;
    end
    chk("b_offers", offers_b, 4);
    chk("b_sb_remaining", qx_b.size(), 0);
    chk("b_frame_done_pulses", done_cnt, 1);
    chk("b_frame_busy_end", ib.frame_busy, 0);
    chk("b_activate_end", ib.activate, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
